blob_table_ctrl: RTL and testbench
==================================

Name: blob_table_ctrl

Overview:
- Sequences the per-frame bounding-box table that sits behind the connected-component segmentation stage of the blob analyzer.
- During a frame it accepts one labelled-pixel update per clock and queues label-merge (collision) requests. Merges are applied only in idle slots.
- At end of frame it drains pending merges and streams one bounding box per surviving blob over a valid/ready interface. It then clears the table for the next frame.
- Runs in the app_clk (video) domain.

Parameters:
- MAX_OBJ_NUM, 15, number of table entries. Tags run 1..MAX_OBJ_NUM; tag 0 means background.
- B_BITS, ceil_log2(MAX_OBJ_NUM+1) = 4, tag width.
- MERGE_FIFO_DEPTH, 4, depth of the merge-request FIFO (power of two).
- CW, 11, coordinate width, matching vid_hpos/vid_vpos.

Ports:
- app_clk  in  1  single clock for the whole block.
- app_rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse, first pixel of a frame follows.
- frame_end  in  1  one-cycle pulse, after the last processed pixel.
- px_valid  in  1  labelled pixel present this cycle.
- px_tag  in  B_BITS  pixel label; 0 = background.
- px_hpos  in  CW  pixel column.
- px_vpos  in  CW  pixel row.
- merge_req  in  1  collision: fold merge_drop into merge_keep.
- merge_keep  in  B_BITS  surviving tag.
- merge_drop  in  B_BITS  absorbed tag.
- merge_full  out  1  merge FIFO holds MERGE_FIFO_DEPTH entries.
- res_valid  out  1  result beat valid.
- res_ready  in  1  consumer accepts the beat.
- res_tag  out  B_BITS  blob tag.
- res_xmin, res_xmax, res_ymin, res_ymax  out  CW each  bounding box.
- res_last  out  1  final beat of the frame.
- done  out  1  one-cycle pulse when reporting finishes.
- blob_num  out  B_BITS  count of blobs reported in the last frame.
- busy  out  1  state is not IDLE.
- err_overflow  out  1  sticky error; cleared by an accepted frame_start.

Behaviour:
- Reset (async, app_rst_n=0): state IDLE, all entries invalid, alias[t]=t, FIFO empty. All outputs are 0.
- Table: per tag t, the fields are valid, xmin, xmax, ymin, ymax and alias[t]. alias[t] is a single-level redirect.
- FSM is IDLE -> ACCUM -> DRAIN -> REPORT -> CLEAR -> IDLE.
- IDLE:
  - frame_start: clear err_overflow, go to ACCUM.
  - px_valid and merge_req are ignored.
- ACCUM, pixel update (px_valid=1, px_tag!=0):
  - Target is e = alias[px_tag].
  - If e is invalid: set valid, and min = max = the pixel coordinates.
  - Otherwise: apply min/max update on both axes.
  - The update is visible to the next cycle's update with no read-modify-write hazard. Back-to-back updates to the same tag must accumulate correctly.
- ACCUM, merge requests:
  - merge_req pushes {keep, drop} into the FIFO. A push while full is dropped and sets err_overflow, even if a pop happens in the same cycle.
  - The FIFO head is popped and applied only in cycles with px_valid=0; pixel updates have priority.
- Merge apply, with k = alias[keep] and d = alias[drop]:
  - The merge is discarded if k==d, k==0 or d==0.
  - Otherwise, entry k becomes the union of k and d. If only one of them is valid, k takes that one's box.
  - entry d becomes invalid, and every alias entry equal to d is rewritten to k.
  - One merge takes one cycle.
- frame_end in ACCUM goes to DRAIN.
  - frame_end wins over a simultaneous frame_start.
  - A merge_req in the same cycle as frame_end is still accepted.
- frame_start in ACCUM without frame_end restarts the frame: table cleared, FIFO flushed, state stays ACCUM.
- DRAIN:
  - px_valid is ignored; merge_req is still accepted.
  - Pops one merge per cycle until the FIFO is empty, then goes to REPORT.
- REPORT:
  - Scans tags 1..MAX_OBJ_NUM in ascending order and presents each valid entry.
  - Skipping an invalid entry costs 1 cycle.
  - While res_valid=1, all res_* outputs are held stable until res_ready=1. The beat transfers on res_valid & res_ready.
  - res_last=1 on the highest-tag valid entry.
  - After the last beat, or after the scan ends with zero valid entries (no beats emitted): done pulses for 1 cycle, blob_num takes the number of beats, and the state goes to CLEAR.
- CLEAR: 1 cycle that invalidates all entries, resets aliases and empties the FIFO, then goes to IDLE.
- frame_start in DRAIN, REPORT or CLEAR is ignored and sets err_overflow.
- busy=1 in every state except IDLE.
- Coordinates are taken as is, with no range check. Tag values above MAX_OBJ_NUM are treated as 0.

Test Plan:
- Single blob: pixels with tag 1 at (10,5), (12,5), (11,7), then frame_end, res_ready=1 -> one beat with tag 1, box (10,12,5,7), res_last=1; then done, blob_num=1, state IDLE.
- Merge: tag 1 box (0..3, 0..0) and tag 2 box (8..9, 1..1); merge keep=1, drop=2 with px_valid=0; later pixel with tag 2 at (20,2) -> single beat with tag 1, box (0,20,0,2).
- Backpressure: 3 blobs with res_ready toggling every other cycle -> beats for tags in ascending order, outputs stable while stalled, res_last only on the 3rd beat, blob_num=3.
- FIFO overflow: 5 merge_req while px_valid is held at 1 (DEPTH=4) -> merge_full=1 after the 4th, err_overflow=1, 5th request lost; next frame_start clears err_overflow.
- Empty frame: frame_start then frame_end with no pixels -> no res_valid, done pulses, blob_num=0.
- Async reset asserted mid-REPORT while res_valid=1 -> res_valid=0 immediately, state IDLE, table empty.

Source files
------------

// File: rtl/blob_table_ctrl.sv
// Per-frame bounding-box table for the blob analyzer. Accumulates labelled
// pixels, folds queued label merges into the table in idle slots, then
// streams one box per surviving blob and clears the table for the next frame.
module blob_table_ctrl #(
  parameter int MAX_OBJ_NUM      = 15,
  parameter int B_BITS           = 4,
  parameter int MERGE_FIFO_DEPTH = 4,
  parameter int CW               = 11
) (
  input  logic              app_clk,
  input  logic              app_rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              px_valid,
  input  logic [B_BITS-1:0] px_tag,
  input  logic [CW-1:0]     px_hpos,
  input  logic [CW-1:0]     px_vpos,
  input  logic              merge_req,
  input  logic [B_BITS-1:0] merge_keep,
  input  logic [B_BITS-1:0] merge_drop,
  output logic              merge_full,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [B_BITS-1:0] res_tag,
  output logic [CW-1:0]     res_xmin,
  output logic [CW-1:0]     res_xmax,
  output logic [CW-1:0]     res_ymin,
  output logic [CW-1:0]     res_ymax,
  output logic              res_last,
  output logic              done,
  output logic [B_BITS-1:0] blob_num,
  output logic              busy,
  output logic              err_overflow
);
  localparam int NE = MAX_OBJ_NUM + 1;
  localparam int PW = $clog2(MERGE_FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_REPORT, S_CLEAR} state_t;

  state_t state, state_nx;

  // Table: entry valid bits, single-level alias redirect, box coordinates.
  logic [NE-1:0]     ent_valid;
  logic [B_BITS-1:0] alias_tag [NE];
  logic [CW-1:0]     box_xmin [NE];
  logic [CW-1:0]     box_xmax [NE];
  logic [CW-1:0]     box_ymin [NE];
  logic [CW-1:0]     box_ymax [NE];

  // Merge request FIFO; pointers carry one extra wrap bit.
  logic [B_BITS-1:0] fifo_keep [MERGE_FIFO_DEPTH];
  logic [B_BITS-1:0] fifo_drop [MERGE_FIFO_DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              fifo_empty;

  logic [B_BITS-1:0] ptr, beat_cnt;
  logic tbl_clear, fifo_flush, push_en, pop_en, px_en;
  logic scan_init, scan_step, finish, err_set, err_clr;

  // Tags beyond the table size behave like background.
  function automatic logic [B_BITS-1:0] clip_tag(input logic [B_BITS-1:0] t);
    return (32'(t) <= MAX_OBJ_NUM) ? t : '0;
  endfunction

  logic [B_BITS-1:0] px_tag_c, px_ent, head_keep, head_drop, mk, md;
  logic merge_en, cur_valid, has_more, beat;

  assign px_tag_c   = clip_tag(px_tag);
  assign px_ent     = alias_tag[px_tag_c];
  assign head_keep  = fifo_keep[rd_ptr[PW-1:0]];
  assign head_drop  = fifo_drop[rd_ptr[PW-1:0]];
  assign mk         = alias_tag[head_keep];
  assign md         = alias_tag[head_drop];
  assign merge_en   = pop_en && (mk != md) && (mk != '0) && (md != '0);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign merge_full = ((wr_ptr - rd_ptr) == (PW+1)'(MERGE_FIFO_DEPTH));
  assign cur_valid  = ent_valid[ptr];
  assign has_more   = |((ent_valid >> ptr) >> 1);
  assign beat       = res_valid && res_ready;
  assign busy       = (state != S_IDLE);

  // Result beat comes straight from the scanned entry; held while stalled.
  assign res_valid = (state == S_REPORT) && cur_valid;
  assign res_tag   = res_valid ? ptr : '0;
  assign res_xmin  = res_valid ? box_xmin[ptr] : '0;
  assign res_xmax  = res_valid ? box_xmax[ptr] : '0;
  assign res_ymin  = res_valid ? box_ymin[ptr] : '0;
  assign res_ymax  = res_valid ? box_ymax[ptr] : '0;
  assign res_last  = res_valid && !has_more;

  // State register.
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!app_rst_n) state <= S_IDLE;
    else            state <= state_nx;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_nx   = state;
    tbl_clear  = 1'b0;
    fifo_flush = 1'b0;
    push_en    = 1'b0;
    pop_en     = 1'b0;
    px_en      = 1'b0;
    scan_init  = 1'b0;
    scan_step  = 1'b0;
    finish     = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          err_clr  = 1'b1;
          state_nx = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (frame_start && !frame_end) begin
          tbl_clear  = 1'b1;
          fifo_flush = 1'b1;
          err_clr    = 1'b1;
        end else begin
          push_en = merge_req;
          px_en   = px_valid && (px_tag_c != '0);
          pop_en  = !px_valid && !fifo_empty;
          if (frame_end) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        push_en = merge_req;
        err_set = frame_start;
        pop_en  = !fifo_empty;
        if (fifo_empty) begin
          scan_init = 1'b1;
          state_nx  = S_REPORT;
        end
      end
      S_REPORT: begin
        err_set = frame_start;
        if (cur_valid) begin
          if (res_ready) begin
            if (has_more) begin
              scan_step = 1'b1;
            end else begin
              finish   = 1'b1;
              state_nx = S_CLEAR;
            end
          end
        end else if (ptr == B_BITS'(MAX_OBJ_NUM)) begin
          finish   = 1'b1;
          state_nx = S_CLEAR;
        end else begin
          scan_step = 1'b1;
        end
      end
      S_CLEAR: begin
        err_set    = frame_start;
        tbl_clear  = 1'b1;
        fifo_flush = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Entry valid bits and alias redirects.
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n || tbl_clear) begin
      ent_valid <= '0;
      for (int t = 0; t < NE; t++) alias_tag[t] <= B_BITS'(t);
    end else if (px_en) begin
      ent_valid[px_ent] <= 1'b1;
    end else if (merge_en) begin
      ent_valid[mk] <= ent_valid[mk] | ent_valid[md];
      ent_valid[md] <= 1'b0;
      for (int t = 0; t < NE; t++)
        if (alias_tag[t] == md) alias_tag[t] <= mk;
    end
  end

  // Box coordinates: seed on first pixel, widen on later ones, union on merge.
  always_ff @(posedge app_clk) begin
    // NOTE: box storage is not reset; ent_valid gates every read, so stale coordinates are never observed.
    if (px_en) begin
      if (!ent_valid[px_ent] || px_hpos < box_xmin[px_ent]) box_xmin[px_ent] <= px_hpos;
      if (!ent_valid[px_ent] || px_hpos > box_xmax[px_ent]) box_xmax[px_ent] <= px_hpos;
      if (!ent_valid[px_ent] || px_vpos < box_ymin[px_ent]) box_ymin[px_ent] <= px_vpos;
      if (!ent_valid[px_ent] || px_vpos > box_ymax[px_ent]) box_ymax[px_ent] <= px_vpos;
    end else if (merge_en && ent_valid[md]) begin
      if (!ent_valid[mk] || box_xmin[md] < box_xmin[mk]) box_xmin[mk] <= box_xmin[md];
      if (!ent_valid[mk] || box_xmax[md] > box_xmax[mk]) box_xmax[mk] <= box_xmax[md];
      if (!ent_valid[mk] || box_ymin[md] < box_ymin[mk]) box_ymin[mk] <= box_ymin[md];
      if (!ent_valid[mk] || box_ymax[md] > box_ymax[mk]) box_ymax[mk] <= box_ymax[md];
    end
  end

  // FIFO pointers; a push into a full FIFO is dropped.
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n || fifo_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en && !merge_full) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop_en)                 rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // FIFO payload, tags clipped on entry.
  always_ff @(posedge app_clk) begin
    if (push_en && !merge_full) begin
      fifo_keep[wr_ptr[PW-1:0]] <= clip_tag(merge_keep);
      fifo_drop[wr_ptr[PW-1:0]] <= clip_tag(merge_drop);
    end
  end

  // Report scan pointer, beat count, done pulse and blob count.
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      ptr      <= '0;
      beat_cnt <= '0;
      done     <= 1'b0;
      blob_num <= '0;
    end else begin
      done <= finish;
      if (scan_init)      ptr <= B_BITS'(1);
      else if (scan_step) ptr <= ptr + B_BITS'(1);
      if (scan_init)      beat_cnt <= '0;
      else if (beat)      beat_cnt <= beat_cnt + B_BITS'(1);
      if (finish)         blob_num <= beat_cnt + B_BITS'(beat);
    end
  end

  // Sticky error: overflowing push or frame_start outside IDLE/ACCUM.
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n)                                err_overflow <= 1'b0;
    else if (err_clr)                              err_overflow <= 1'b0;
    else if (err_set || (push_en && merge_full))   err_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_blob_table_ctrl.sv
// Self-checking bench for blob_table_ctrl: directed frames plus randomized
// frames, checked against a transaction-level model of the box table.
module tb_blob_table_ctrl;
  localparam int MAXO  = 15;
  localparam int DEPTH = 4;

  logic        app_clk = 1'b0;
  logic        app_rst_n = 1'b0;
  logic        frame_start = 1'b0, frame_end = 1'b0, px_valid = 1'b0;
  logic [3:0]  px_tag = '0;
  logic [10:0] px_hpos = '0, px_vpos = '0;
  logic        merge_req = 1'b0;
  logic [3:0]  merge_keep = '0, merge_drop = '0;
  logic        merge_full, res_valid, res_last, done, busy, err_overflow;
  logic        res_ready = 1'b0;
  logic [3:0]  res_tag, blob_num;
  logic [10:0] res_xmin, res_xmax, res_ymin, res_ymax;

  blob_table_ctrl dut (
    .app_clk(app_clk), .app_rst_n(app_rst_n),
    .frame_start(frame_start), .frame_end(frame_end),
    .px_valid(px_valid), .px_tag(px_tag), .px_hpos(px_hpos), .px_vpos(px_vpos),
    .merge_req(merge_req), .merge_keep(merge_keep), .merge_drop(merge_drop),
    .merge_full(merge_full),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_xmin(res_xmin), .res_xmax(res_xmax), .res_ymin(res_ymin), .res_ymax(res_ymax),
    .res_last(res_last), .done(done), .blob_num(blob_num),
    .busy(busy), .err_overflow(err_overflow)
  );

  always #5 app_clk = ~app_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one box per tag, alias redirect, merge queue, error flag.
  int m_valid [16];
  int m_xmin [16], m_xmax [16], m_ymin [16], m_ymax [16];
  int m_alias [16];
  int mq [$];
  bit m_err = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < 16; t++) begin
      m_valid[t] = 0;
      m_alias[t] = t;
    end
    mq.delete();
  endtask

  task automatic model_pixel(input int tag, input int h, input int v);
    int e;
    e = m_alias[tag];
    if (m_valid[e] == 0) begin
      m_valid[e] = 1;
      m_xmin[e] = h; m_xmax[e] = h; m_ymin[e] = v; m_ymax[e] = v;
    end else begin
      m_xmin[e] = imin(m_xmin[e], h); m_xmax[e] = imax(m_xmax[e], h);
      m_ymin[e] = imin(m_ymin[e], v); m_ymax[e] = imax(m_ymax[e], v);
    end
  endtask

  task automatic model_merge(input int keep, input int drop);
    int k, d;
    k = m_alias[keep];
    d = m_alias[drop];
    if (k == d || k == 0 || d == 0) return;
    if (m_valid[k] != 0 && m_valid[d] != 0) begin
      m_xmin[k] = imin(m_xmin[k], m_xmin[d]); m_xmax[k] = imax(m_xmax[k], m_xmax[d]);
      m_ymin[k] = imin(m_ymin[k], m_ymin[d]); m_ymax[k] = imax(m_ymax[k], m_ymax[d]);
    end else if (m_valid[d] != 0) begin
      m_valid[k] = 1;
      m_xmin[k] = m_xmin[d]; m_xmax[k] = m_xmax[d];
      m_ymin[k] = m_ymin[d]; m_ymax[k] = m_ymax[d];
    end
    m_valid[d] = 0;
    for (int t = 0; t < 16; t++) if (m_alias[t] == d) m_alias[t] = k;
  endtask

  function automatic logic [63:0] pack(input int tag, input int x0, input int x1,
                                       input int y0, input int y1, input bit last);
    return {15'd0, 4'(tag), 11'(x0), 11'(x1), 11'(y0), 11'(y1), last};
  endfunction

  function automatic logic [63:0] dut_beat();
    return {15'd0, res_tag, res_xmin, res_xmax, res_ymin, res_ymax, res_last};
  endfunction

  // One ACCUM cycle: optional pixel and optional merge request.
  task automatic acc_cycle(input bit pv, input int tag, input int h, input int v,
                           input bit mr, input int keep, input int drop);
    bit was_full, can_pop;
    was_full = (mq.size() == DEPTH);
    can_pop  = (mq.size() != 0);
    px_valid = pv; px_tag = 4'(tag); px_hpos = 11'(h); px_vpos = 11'(v);
    merge_req = mr; merge_keep = 4'(keep); merge_drop = 4'(drop);
    tick();
    px_valid = 1'b0; merge_req = 1'b0;
    if (pv) begin
      if (tag != 0) model_pixel(tag, h, v);
    end else if (can_pop) begin
      int e;
      e = mq.pop_front();
      model_merge(e / 16, e % 16);
    end
    if (mr) begin
      if (was_full) m_err = 1'b1;
      else          mq.push_back(keep * 16 + drop);
    end
    check("merge_full", merge_full, mq.size() == DEPTH);
    check("err_overflow", err_overflow, m_err);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_err = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_after_start", err_overflow, 0);
  endtask

  // frame_start inside ACCUM: pixel and merge on the same cycle are discarded.
  task automatic restart_frame();
    frame_start = 1'b1; px_valid = 1'b1; px_tag = 4'd1; merge_req = 1'b1;
    merge_keep = 4'd1; merge_drop = 4'd2;
    tick();
    frame_start = 1'b0; px_valid = 1'b0; merge_req = 1'b0;
    model_clear();
    m_err = 1'b0;
    check("restart_full", merge_full, 0);
    check("restart_err", err_overflow, 0);
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    while (mq.size() != 0) begin
      int e;
      e = mq.pop_front();
      model_merge(e / 16, e % 16);
    end
  endtask

  // Collect the report. ready_mode: 0 always, 1 toggling, 2 random.
  task automatic run_report(input int ready_mode, input bit poke);
    logic [63:0] exp_q [$];
    logic [63:0] held;
    int idx, n_exp;
    bit seen_done, prev_stall, rdy;
    for (int t = 1; t <= MAXO; t++)
      if (m_valid[t] != 0) exp_q.push_back(pack(t, m_xmin[t], m_xmax[t], m_ymin[t], m_ymax[t], 1'b0));
    n_exp = exp_q.size();
    if (n_exp > 0) exp_q[n_exp-1][0] = 1'b1;
    idx = 0; seen_done = 1'b0; prev_stall = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (prev_stall) begin
        check("hold_valid", res_valid, 1);
        check("hold_beat", dut_beat(), held);
      end
      if (ready_mode == 0)      rdy = 1'b1;
      else if (ready_mode == 1) rdy = cyc[0];
      else                      rdy = 1'($urandom_range(0, 1));
      res_ready = rdy;
      frame_start = poke && (cyc == 0);
      if (res_valid && rdy) begin
        if (idx < n_exp) check("beat", dut_beat(), exp_q[idx]);
        else             check("extra_beat", res_valid, 0);
        idx++;
      end
      prev_stall = res_valid && !rdy;
      held = dut_beat();
      tick();
      frame_start = 1'b0;
    end
    if (poke) m_err = 1'b1;
    res_ready = 1'b0;
    check("done_seen", seen_done, 1);
    check("beat_count", idx, n_exp);
    check("blob_num", blob_num, n_exp);
    check("valid_after_done", res_valid, 0);
    check("err_at_done", err_overflow, m_err);
    tick();
    check("done_pulse_len", done, 0);
    check("busy_idle", busy, 0);
    model_clear();
  endtask

  initial begin
    bit seen;
    model_clear();
    repeat (2) @(posedge app_clk);
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_blob_num", blob_num, 0);
    check("rst_merge_full", merge_full, 0);
    check("rst_err", err_overflow, 0);
    check("rst_res_last", res_last, 0);
    app_rst_n = 1'b1;
    tick();

    // Single blob.
    start_frame();
    acc_cycle(1, 1, 10, 5, 0, 0, 0);
    acc_cycle(1, 1, 12, 5, 0, 0, 0);
    acc_cycle(1, 1, 11, 7, 0, 0, 0);
    end_frame();
    run_report(0, 0);

    // Merge, then a pixel on the absorbed tag.
    start_frame();
    acc_cycle(1, 1, 0, 0, 0, 0, 0);
    acc_cycle(1, 1, 3, 0, 0, 0, 0);
    acc_cycle(1, 2, 8, 1, 0, 0, 0);
    acc_cycle(1, 2, 9, 1, 0, 0, 0);
    acc_cycle(0, 0, 0, 0, 1, 1, 2);
    acc_cycle(0, 0, 0, 0, 0, 0, 0);
    acc_cycle(1, 2, 20, 2, 0, 0, 0);
    end_frame();
    run_report(2, 0);

    // Backpressure with three blobs; frame_start poked while busy.
    start_frame();
    acc_cycle(1, 9, 100, 40, 0, 0, 0);
    acc_cycle(1, 2, 7, 3, 0, 0, 0);
    acc_cycle(1, 5, 2047, 2047, 0, 0, 0);
    acc_cycle(1, 2, 1, 9, 0, 0, 0);
    end_frame();
    run_report(1, 1);

    // FIFO overflow while pixels hold the pop slot.
    start_frame();
    acc_cycle(1, 4, 30, 30, 0, 0, 0);
    acc_cycle(1, 6, 50, 10, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      acc_cycle(1, 3, 40 + i, 20, 1, 3, 4 + i);
      if (i == 3) check("ovf_full_after_4", merge_full, 1);
    end
    check("ovf_err", err_overflow, 1);
    end_frame();
    run_report(0, 0);
    start_frame();
    end_frame();
    run_report(0, 0);

    // Randomized frames, occasionally restarted mid-frame.
    for (int f = 0; f < 30; f++) begin
      int ncyc, rst_at;
      start_frame();
      ncyc   = $urandom_range(10, 40);
      rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ncyc - 1) : -1;
      for (int c = 0; c < ncyc; c++) begin
        if (c == rst_at) restart_frame();
        acc_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 6),
                  $urandom_range(0, 2047), $urandom_range(0, 2047),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 6), $urandom_range(0, 6));
      end
      end_frame();
      run_report(2, 0);
    end

    // Asynchronous reset during REPORT with a beat pending.
    start_frame();
    acc_cycle(1, 1, 5, 5, 0, 0, 0);
    acc_cycle(1, 3, 9, 9, 0, 0, 0);
    end_frame();
    res_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("rst_mid_valid_seen", seen, 1);
    #2 app_rst_n = 1'b0;
    #1;
    check("rst_mid_res_valid", res_valid, 0);
    check("rst_mid_res_tag", res_tag, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_blob_num", blob_num, 0);
    check("rst_mid_done", done, 0);
    #2 app_rst_n = 1'b1;
    model_clear();
    m_err = 1'b0;
    tick();
    start_frame();
    end_frame();
    run_report(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
